// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM; optional WAIT/DRAIN timeout enabled by defining FETCH_TIMEOUT_EN
module fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, instr_q, instr_d, ipc_q, ipc_d;
  logic        timeout;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, waiting;
  assign waiting = (state_q == WAIT || state_q == DRAIN) && !imem_rsp_valid;
  assign cnt_d = waiting ? cnt_q + CW'(cnt_q != '1) : '0;
  assign timeout = waiting && cnt_q >= CW'(TIMEOUT_CYCLES - 1);
  assign fetch_err = err_q;
  // Count consecutive response-less WAIT/DRAIN cycles; a timeout latches a sticky error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (timeout && !flush);
    end
`else
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  assign imem_req_valid = state_q == REQ;
  assign imem_addr = imem_req_valid ? pc_in : addr_q;
  assign instr_valid = state_q == HOLD;
  assign pc_write = instr_valid && instr_ready && !flush;
  assign instr = instr_q;
  assign instr_pc = ipc_q;
  // Next state and datapath updates; flush wins over every other event
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    case (state_q)
      IDLE:  if (!fetch_err) state_d = REQ;
      REQ:   if (imem_req_ready) begin
               addr_d = pc_in;
               state_d = flush ? DRAIN : WAIT;
             end
      WAIT:  if (flush) state_d = imem_rsp_valid ? REQ : DRAIN;
             else if (imem_rsp_valid) begin
               instr_d = imem_rdata;
               ipc_d = addr_q;
               state_d = HOLD;
             end else if (timeout) state_d = IDLE;
      DRAIN: if (imem_rsp_valid) state_d = REQ;
             else if (!flush && timeout) state_d = IDLE;
      HOLD:  if (flush || instr_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      instr_q <= '0;
      ipc_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard checking every consumed instruction
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_in, pc, tgt;
  logic        pc_write, flush, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  logic        instr_valid, instr_ready, fetch_err;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  int          checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_write(pc_write), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  assign pc_in = pc;

  // pc register of the surrounding pipeline
  always @(posedge clk or negedge rst)
    if (!rst) pc <= 32'h0;
    else if (flush) pc <= tgt;
    else if (pc_write) pc <= pc + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: every consumed instruction must match the oldest expected entry
  always @(negedge clk)
    if (rst && pc_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got instr %h pc %h expected none", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e[63:32]);
        chk("sb_instr_pc", instr_pc, e[31:0]);
      end
    end

  // from REQ: accept, respond next cycle, end in HOLD
  task automatic fetch(input logic [31:0] data, input bit keep);
    logic [31:0] a;
    a = pc;
    imem_req_ready = 1'b1;
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, a);
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata = data;
    if (keep) exp_q.push_back({data, a});
    chk("wait_no_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    imem_rsp_valid = 1'b0;
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_instr", instr, data);
    chk("hold_pc", instr_pc, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    flush = 1'b0; tgt = 32'h0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc_write", {31'b0, pc_write}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b1;
    chk("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick;
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    // normal fetch
    fetch(32'h00500093, 1'b1);
    chk("pc_write_pulse", {31'b0, pc_write}, 32'd1);
    tick;
    chk("pc_write_single", {31'b0, pc_write}, 32'd0);
    chk("next_addr", imem_addr, 32'h4);
    // backpressure
    instr_ready = 1'b0;
    fetch(32'h00A00113, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_pc_write", {31'b0, pc_write}, 32'd0);
      chk("bp_instr", instr, 32'h00A00113);
      chk("bp_pc", instr_pc, 32'h4);
      tick;
    end
    instr_ready = 1'b1;
    #1;
    chk("bp_release", {31'b0, pc_write}, 32'd1);
    tick;
    chk("bp_single", {31'b0, pc_write}, 32'd0);
    // request stall
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, 32'h8);
      tick;
    end
    fetch(32'h00100193, 1'b1);
    tick;
    // flush in WAIT, stale response two cycles later
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    flush = 1'b1; tgt = 32'h104;
    #1;
    chk("flw_no_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    flush = 1'b0;
    chk("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick;
    imem_rsp_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    chk("drain_no_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    imem_rsp_valid = 1'b0;
    chk("post_drain_valid", {31'b0, instr_valid}, 32'd0);
    chk("post_drain_req", {31'b0, imem_req_valid}, 32'd1);
    chk("post_drain_addr", imem_addr, 32'h104);
    fetch(32'h00000013, 1'b1);
    tick;
    // flush in HOLD beats instr_ready
    instr_ready = 1'b0;
    fetch(32'h11111111, 1'b0);
    flush = 1'b1; tgt = 32'h200; instr_ready = 1'b1;
    #1;
    chk("flh_pc_write", {31'b0, pc_write}, 32'd0);
    tick;
    flush = 1'b0;
    chk("flh_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("flh_addr", imem_addr, 32'h200);
    // flush in WAIT together with the response
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    flush = 1'b1; tgt = 32'h300; imem_rsp_valid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    tick;
    flush = 1'b0; imem_rsp_valid = 1'b0;
    chk("flr_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("flr_req", {31'b0, imem_req_valid}, 32'd1);
    chk("flr_addr", imem_addr, 32'h300);
    fetch(32'h00200213, 1'b1);
    tick;
    // reset mid-WAIT
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mr_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mr_pc_write", {31'b0, pc_write}, 32'd0);
    chk("mr_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_instr_pc", instr_pc, 32'h0);
    tick;
    rst = 1'b1;
    chk("mr_idle", {31'b0, imem_req_valid}, 32'd0);
    tick;
    chk("mr_req", {31'b0, imem_req_valid}, 32'd1);
    chk("mr_req_addr", imem_addr, 32'h0);
`ifdef FETCH_TIMEOUT_EN
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_no_err", {31'b0, fetch_err}, 32'd0);
      tick;
    end
    chk("to_last_wait", {31'b0, fetch_err}, 32'd0);
    tick;
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("to_halt", {31'b0, imem_req_valid}, 32'd0);
      chk("to_sticky", {31'b0, fetch_err}, 32'd1);
      tick;
    end
`else
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("lw_no_err", {31'b0, fetch_err}, 32'd0);
      chk("lw_no_req", {31'b0, imem_req_valid}, 32'd0);
      tick;
    end
    imem_rsp_valid = 1'b1; imem_rdata = 32'h00300293;
    exp_q.push_back({32'h00300293, 32'h0});
    tick;
    imem_rsp_valid = 1'b0;
    chk("lw_valid", {31'b0, instr_valid}, 32'd1);
    tick;
`endif
    tick;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
